// File: rtl/ext_sram_ctrl.sv
// Asynchronous external SRAM controller: turns a level cs/ack bus request into
// a SETUP / STROBE / RECOVER SRAM cycle with a programmable strobe width.
`timescale 1ns/1ps

module ext_sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  output logic        o_ack,
  output logic [15:0] o_sram_addr,
  output logic [7:0]  o_sram_dq,
  output logic        o_sram_dq_oe,
  input  logic [7:0]  i_sram_dq,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n
);

  localparam int         WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;

  state_t     state;
  logic       we_q;
  logic [3:0] wait_cnt;

  // NOTE: every register here, including the strobes, sits on the async reset so
  // a reset mid-cycle releases the SRAM bus immediately, without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      wait_cnt     <= '0;
      o_dat        <= '0;
      o_ack        <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_ce_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout so every output is a clean
      // flop fed by the previous-cycle state.
      case (state)
        IDLE: begin
          o_ack <= 1'b0;
          if (i_cs) begin
            o_sram_addr  <= i_addr;
            o_sram_dq    <= i_dat;
            we_q         <= i_we;
            o_sram_dq_oe <= i_we;
            state        <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt    <= WAIT_LOAD;
          o_sram_ce_n <= 1'b0;
          o_sram_oe_n <= we_q;
          o_sram_we_n <= !we_q;
          state       <= STROBE;
        end
        STROBE: begin
          if (wait_cnt == '0) begin
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            if (!we_q) o_dat <= i_sram_dq;
            state <= RECOVER;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RECOVER: begin
          // Write data was held through this cycle for SRAM hold time.
          o_sram_dq_oe <= 1'b0;
          state        <= i_cs ? DONE : IDLE;
        end
        DONE: begin
          // ack flop follows DONE one edge later; dropping cs clears it on the same edge.
          if (!i_cs) begin
            o_ack <= 1'b0;
            state <= IDLE;
          end else begin
            o_ack <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Directed bench for ext_sram_ctrl: behavioural SRAM, strobe/protocol monitor and
// a scoreboard queue of expected read data / memory contents per access.
`timescale 1ns/1ps

module tb_ext_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // DUT A: default WAIT_CYCLES=2
  logic        a_cs, a_we, a_ack, a_dq_oe, a_ce_n, a_oe_n, a_we_n;
  logic [15:0] a_addr, a_sram_addr;
  logic [7:0]  a_dat, a_rdat, a_sram_dq, a_dq_in;
  // DUT B: WAIT_CYCLES=5
  logic        b_cs, b_we, b_ack, b_dq_oe, b_ce_n, b_oe_n, b_we_n;
  logic [15:0] b_addr, b_sram_addr;
  logic [7:0]  b_dat, b_rdat, b_sram_dq, b_dq_in;

  ext_sram_ctrl dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_cs(a_cs), .i_we(a_we), .i_addr(a_addr),
    .i_dat(a_dat), .o_dat(a_rdat), .o_ack(a_ack), .o_sram_addr(a_sram_addr),
    .o_sram_dq(a_sram_dq), .o_sram_dq_oe(a_dq_oe), .i_sram_dq(a_dq_in),
    .o_sram_ce_n(a_ce_n), .o_sram_oe_n(a_oe_n), .o_sram_we_n(a_we_n)
  );

  ext_sram_ctrl #(.WAIT_CYCLES(5)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_cs(b_cs), .i_we(b_we), .i_addr(b_addr),
    .i_dat(b_dat), .o_dat(b_rdat), .o_ack(b_ack), .o_sram_addr(b_sram_addr),
    .o_sram_dq(b_sram_dq), .o_sram_dq_oe(b_dq_oe), .i_sram_dq(b_dq_in),
    .o_sram_ce_n(b_ce_n), .o_sram_oe_n(b_oe_n), .o_sram_we_n(b_we_n)
  );

  // Shared SRAM array; reads are combinational while ce/oe are low.
  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  assign a_dq_in = (!a_ce_n && !a_oe_n) ? mem[a_sram_addr] : 8'hEE;
  assign b_dq_in = (!b_ce_n && !b_oe_n) ? mem[b_sram_addr] : 8'hEE;

  int   a_oe_cyc = 0, a_we_cyc = 0, a_dqoe_cyc = 0, a_acc = 0, a_viol = 0;
  int   b_oe_cyc = 0, b_acc = 0, b_viol = 0;
  logic a_ce_prev = 1'b1, b_ce_prev = 1'b1;

  // Counts cycles (ending at this edge) each strobe was active, plus access starts.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (!a_ce_n && !a_we_n && a_dq_oe) mem[a_sram_addr] <= a_sram_dq;
    if (!a_oe_n)  a_oe_cyc   <= a_oe_cyc + 1;
    if (!a_we_n)  a_we_cyc   <= a_we_cyc + 1;
    if (a_dq_oe)  a_dqoe_cyc <= a_dqoe_cyc + 1;
    if (!b_oe_n)  b_oe_cyc   <= b_oe_cyc + 1;
    if (a_ce_prev && !a_ce_n) a_acc <= a_acc + 1;
    if (b_ce_prev && !b_ce_n) b_acc <= b_acc + 1;
    if ((a_dq_oe && !a_oe_n) || (!a_we_n && a_ce_n)) a_viol <= a_viol + 1;
    if ((b_dq_oe && !b_oe_n) || (!b_we_n && b_ce_n)) b_viol <= b_viol + 1;
    a_ce_prev <= a_ce_n;
    b_ce_prev <= b_ce_n;
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } sb_item_t;
  sb_item_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] addr, input logic [7:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request on DUT A from a negedge; returns at the negedge where ack
  // is first seen (cs still high). Inputs are scrambled right after the latch edge.
  task automatic access_a(input logic we, input logic [15:0] addr, input logic [7:0] dat,
                          output int lat);
    sb_item_t item;
    sb_q.push_back('{we: we, addr: addr, data: (we ? dat : mem[addr])});
    a_cs = 1'b1; a_we = we; a_addr = addr; a_dat = dat;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_we = ~we; a_addr = ~addr; a_dat = ~dat;
      end
      if (a_ack) begin
        lat = n - 1;
        break;
      end
    end
    check("ack_seen", 32'(a_ack), 32'd1);
    item = sb_q.pop_front();
    if (item.we) check("sb_wr_mem", 32'(mem[item.addr]), 32'(item.data));
    else         check("sb_rd_data", 32'(a_rdat), 32'(item.data));
  endtask

  int lat, s_oe, s_we, s_dqoe, s_acc, hits;

  initial begin
    rst_n = 1'b0;
    a_cs = 1'b0; a_we = 1'b0; a_addr = '0; a_dat = '0;
    b_cs = 1'b0; b_we = 1'b0; b_addr = '0; b_dat = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ack",   32'(a_ack), 32'd0);
    check("rst_dat",   32'(a_rdat), 32'd0);
    check("rst_addr",  32'(a_sram_addr), 32'd0);
    check("rst_dq",    32'(a_sram_dq), 32'd0);
    check("rst_dq_oe", 32'(a_dq_oe), 32'd0);
    check("rst_strb",  32'({a_ce_n, a_oe_n, a_we_n}), 32'h7);
    rst_n = 1'b1;
    @(negedge clk);

    preload(16'h1234, 8'h5A);
    preload(16'h00FF, 8'h3C);
    preload(16'h0200, 8'h77);
    preload(16'h0300, 8'h11);

    // Basic read
    s_oe = a_oe_cyc;
    access_a(1'b0, 16'h1234, 8'h00, lat);
    check("rd_latency", 32'(lat), 32'd5);
    check("rd_oe_cycles", 32'(a_oe_cyc - s_oe), 32'd2);
    check("rd_value", 32'(a_rdat), 32'h5A);
    a_cs = 1'b0;
    @(negedge clk);
    check("rd_ack_drop", 32'(a_ack), 32'd0);

    // Basic write, then read back through the DUT
    s_we = a_we_cyc; s_dqoe = a_dqoe_cyc;
    access_a(1'b1, 16'h8001, 8'hC3, lat);
    check("wr_latency", 32'(lat), 32'd5);
    check("wr_we_cycles", 32'(a_we_cyc - s_we), 32'd2);
    check("wr_dqoe_cycles", 32'(a_dqoe_cyc - s_dqoe), 32'd4);
    check("wr_mem", 32'(mem[16'h8001]), 32'hC3);
    a_cs = 1'b0;
    @(negedge clk);
    access_a(1'b0, 16'h8001, 8'h00, lat);
    check("wr_readback", 32'(a_rdat), 32'hC3);
    a_cs = 1'b0;
    @(negedge clk);

    // Abort: cs high for one edge only on a write
    s_we = a_we_cyc; s_acc = a_acc; hits = 0;
    a_cs = 1'b1; a_we = 1'b1; a_addr = 16'h4444; a_dat = 8'h99;
    @(negedge clk);
    a_cs = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (a_ack) hits++;
    end
    check("abort_ack_hits", 32'(hits), 32'd0);
    check("abort_we_cycles", 32'(a_we_cyc - s_we), 32'd2);
    check("abort_accesses", 32'(a_acc - s_acc), 32'd1);
    check("abort_mem", 32'(mem[16'h4444]), 32'h99);
    access_a(1'b0, 16'h4444, 8'h00, lat);
    check("abort_idle_latency", 32'(lat), 32'd5);
    a_cs = 1'b0;
    @(negedge clk);

    // Hold cs past ack: single access, then reissue
    s_acc = a_acc; hits = 0;
    access_a(1'b0, 16'h00FF, 8'h00, lat);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!a_ack) hits++;
    end
    check("hold_ack_low_cycles", 32'(hits), 32'd0);
    check("hold_single_access", 32'(a_acc - s_acc), 32'd1);
    a_cs = 1'b0;
    @(negedge clk);
    check("hold_ack_drop", 32'(a_ack), 32'd0);
    access_a(1'b0, 16'h00FF, 8'h00, lat);
    check("reissue_latency", 32'(lat), 32'd5);
    check("reissue_accesses", 32'(a_acc - s_acc), 32'd2);
    a_cs = 1'b0;
    @(negedge clk);

    // Async reset during the write strobe
    a_cs = 1'b1; a_we = 1'b1; a_addr = 16'h5555; a_dat = 8'h12;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!a_we_n) break;
    end
    check("rst_mid_we_seen", 32'(a_we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_strb", 32'({a_ce_n, a_we_n}), 32'h3);
    check("rst_mid_dq_oe", 32'(a_dq_oe), 32'd0);
    check("rst_mid_ack", 32'(a_ack), 32'd0);
    a_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s_acc = a_acc;
    repeat (6) @(negedge clk);
    check("rst_no_resume", 32'(a_acc - s_acc), 32'd0);
    access_a(1'b0, 16'h1234, 8'h00, lat);
    check("post_rst_latency", 32'(lat), 32'd5);
    a_cs = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES=5 read with address change during STROBE
    s_oe = b_oe_cyc; lat = -1;
    b_cs = 1'b1; b_we = 1'b0; b_addr = 16'h0200;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3) b_addr = 16'h0300;
      if (n == 4) check("b_addr_stable", 32'(b_sram_addr), 32'h0200);
      if (b_ack) begin
        lat = n - 1;
        break;
      end
    end
    check("b_latency", 32'(lat), 32'd8);
    check("b_oe_cycles", 32'(b_oe_cyc - s_oe), 32'd5);
    check("b_rd_value", 32'(b_rdat), 32'h77);
    b_cs = 1'b0;
    @(negedge clk);
    check("b_ack_drop", 32'(b_ack), 32'd0);

    check("a_protocol", 32'(a_viol), 32'd0);
    check("b_protocol", 32'(b_viol), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
